// File: rtl/sdram_image_writer_if.sv
// rtl/sdram_image_writer_if.sv - download port and SDRAM write-channel signal bundle
interface sdram_image_writer_if;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_busy;
    logic        sd_wr;
    logic [24:0] sd_wr_addr;
    logic [15:0] sd_data;
    logic [1:0]  sd_wr_mask;
    logic        sd_ack;
    logic        load_done;
    logic        overflow;

    modport master (
        input  dl_active, dl_wr, dl_addr, dl_data, sd_ack,
        output dl_busy, sd_wr, sd_wr_addr, sd_data, sd_wr_mask, load_done, overflow
    );

    modport slave (
        output dl_active, dl_wr, dl_addr, dl_data, sd_ack,
        input  dl_busy, sd_wr, sd_wr_addr, sd_data, sd_wr_mask, load_done, overflow
    );
endinterface

// File: rtl/sdram_image_writer.sv
// rtl/sdram_image_writer.sv - interleaves background/mask download bytes into SDRAM byte-lane writes
module sdram_image_writer #(
    parameter int unsigned PLANE_BYTES = 1555200,
    parameter int unsigned BASE_WORD   = 0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk_sys_131_072,
    input  logic                 reset_n,
    sdram_image_writer_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_BUSY = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [25:0] PLANE1_END = 26'(PLANE_BYTES);
    localparam logic [25:0] PLANE2_END = 26'(2 * PLANE_BYTES);
    localparam logic [25:0] BASE26     = 26'(BASE_WORD);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } entry_t;

    state_t             state, state_next;
    logic               load_out;
    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop, drop;
    logic               in_range;
    logic [25:0]        offset, dec_addr;
    logic [1:0]         dec_mask;
    logic               active_q, drain, rise, fall, done_now;

    assign offset = {1'b0, bus.dl_addr};

    // Map the stream offset onto a plane: first plane feeds the low lane, second the high lane
    always_comb begin
        in_range = 1'b1;
        dec_mask = 2'b01;
        dec_addr = BASE26 + offset;
        if (offset < PLANE1_END) begin
            dec_mask = 2'b01;
            dec_addr = BASE26 + offset;
        end else if (offset < PLANE2_END) begin
            dec_mask = 2'b10;
            dec_addr = BASE26 + (offset - PLANE1_END);
        end else begin
            in_range = 1'b0;
        end
    end

    // Fullness is taken from the registered count, so a same-cycle pop never frees a slot
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign push  = bus.dl_wr & in_range & ~full;
    assign drop  = bus.dl_wr & in_range & full;
    assign pop   = (state == ISSUE) & bus.sd_ack;

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk_sys_131_072) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: dec_addr[24:0], data: bus.dl_data, mask: dec_mask};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_sys_131_072 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Write-issue state register
    always_ff @(posedge clk_sys_131_072 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state; every ISSUE is entered with the FIFO head latched onto the bus
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = ISSUE;
                    load_out   = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.sd_ack) state_next = GAP;
            end
            GAP: begin
                if (!empty) begin
                    state_next = ISSUE;
                    load_out   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request payload, held stable for the whole ISSUE phase
    always_ff @(posedge clk_sys_131_072 or negedge reset_n) begin
        if (!reset_n) begin
            bus.sd_wr_addr <= '0;
            bus.sd_data    <= '0;
            bus.sd_wr_mask <= '0;
        end else if (load_out) begin
            bus.sd_wr_addr <= mem[rd_ptr].addr;
            bus.sd_data    <= {mem[rd_ptr].data, mem[rd_ptr].data};
            bus.sd_wr_mask <= mem[rd_ptr].mask;
        end
    end

    assign bus.sd_wr   = (state == ISSUE);
    assign bus.dl_busy = (count >= CNT_BUSY);

    assign rise     = bus.dl_active & ~active_q;
    assign fall     = ~bus.dl_active & active_q;
    assign done_now = drain & empty & (state == IDLE);
    assign bus.load_done = done_now;

    // Download framing: rise starts a fresh load, fall arms the completion pulse
    always_ff @(posedge clk_sys_131_072 or negedge reset_n) begin
        if (!reset_n) begin
            active_q     <= 1'b0;
            drain        <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            active_q <= bus.dl_active;
            if (rise)          drain <= 1'b0;
            else if (fall)     drain <= 1'b1;
            else if (done_now) drain <= 1'b0;
            // A byte lost in the very cycle of a new download belongs to that download
            if (drop)          bus.overflow <= 1'b1;
            else if (rise)     bus.overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdram_image_writer.sv
// tb/tb_sdram_image_writer.sv - scoreboard bench for sdram_image_writer
module tb_sdram_image_writer;
    localparam int unsigned PLANE = 1555200;
    localparam logic [24:0] P1 = 25'(PLANE);
    localparam logic [24:0] P2 = 25'(2 * PLANE);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sdram_image_writer_if bus();

    sdram_image_writer #(
        .PLANE_BYTES(PLANE),
        .BASE_WORD  (0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys_131_072(clk),
        .reset_n        (rst_n),
        .bus            (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [42:0] sb[$];
    int n_acc = 0, n_ld = 0, cyc = 0, last_acc_cyc = 0, ld_cyc = 0, wr_hi = 0;
    bit prev_acc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted write and checks the mandatory gap cycle
    always @(negedge clk) begin
        logic [42:0] exp;
        cyc++;
        if (bus.load_done === 1'b1) begin
            n_ld++;
            ld_cyc = cyc;
        end
        if (bus.sd_wr === 1'b1) wr_hi++;
        if (rst_n === 1'b1 && prev_acc) check("gap_after_write", 64'(bus.sd_wr), 64'd0);
        prev_acc = 1'b0;
        if (rst_n === 1'b1 && bus.sd_wr === 1'b1 && bus.sd_ack === 1'b1) begin
            prev_acc = 1'b1;
            n_acc++;
            last_acc_cyc = cyc;
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("write_entry", 64'({bus.sd_wr_addr, bus.sd_data, bus.sd_wr_mask}), 64'(exp));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit acc,
                      input logic [24:0] ea, input logic [1:0] em);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = a;
        bus.dl_data = d;
        if (acc) sb.push_back({ea, d, d, em});
        step();
        bus.dl_wr = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_sd_wr(input string name, input int budget);
        int n = 0;
        while (bus.sd_wr !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(bus.sd_wr), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n0, ld0, hi0, n;
        bus.dl_active = 1'b0;
        bus.dl_wr     = 1'b0;
        bus.dl_addr   = '0;
        bus.dl_data   = '0;
        bus.sd_ack    = 1'b0;
        rst_n = 1'b0;
        step(2);

        // Reset state
        check("rst_sd_wr",     64'(bus.sd_wr), 64'd0);
        check("rst_addr",      64'(bus.sd_wr_addr), 64'd0);
        check("rst_data",      64'(bus.sd_data), 64'd0);
        check("rst_mask",      64'(bus.sd_wr_mask), 64'd0);
        check("rst_busy",      64'(bus.dl_busy), 64'd0);
        check("rst_load_done", 64'(bus.load_done), 64'd0);
        check("rst_overflow",  64'(bus.overflow), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: single background byte, ack on the third request cycle
        hi0 = wr_hi;
        wr(25'd0, 8'hAB, 1'b1, 25'd0, 2'b01);
        wait_sd_wr("t1_req", 10);
        step(2);
        bus.sd_ack = 1'b1;
        step();
        bus.sd_ack = 1'b0;
        step(2);
        check("t1_wr_high_cycles", 64'(wr_hi - hi0), 64'd3);
        check("t1_wr_low", 64'(bus.sd_wr), 64'd0);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: mask plane byte, then an out-of-range offset
        bus.sd_ack = 1'b1;
        n0 = n_acc;
        wr(P1 + 25'd5, 8'h7E, 1'b1, 25'd5, 2'b10);
        wr(P2, 8'h55, 1'b0, 25'd0, 2'b00);
        wait_sb_empty("t2_drain", 20);
        step(4);
        check("t2_overflow", 64'(bus.overflow), 64'd0);
        check("t2_write_count", 64'(n_acc - n0), 64'd1);

        // 3: controller stalled, FIFO fills and drops
        bus.sd_ack = 1'b0;
        step(2);
        wr(25'd10, 8'h11, 1'b1, 25'd10, 2'b01);
        wr(P1 + 25'd11, 8'h22, 1'b1, 25'd11, 2'b10);
        check("t3_busy_at_2", 64'(bus.dl_busy), 64'd0);
        wr(25'd12, 8'h33, 1'b1, 25'd12, 2'b01);
        check("t3_busy_at_3", 64'(bus.dl_busy), 64'd1);
        wr(25'd13, 8'h44, 1'b1, 25'd13, 2'b01);
        wr(25'd14, 8'h55, 1'b0, 25'd0, 2'b00);
        wr(25'd15, 8'h66, 1'b0, 25'd0, 2'b00);
        check("t3_overflow", 64'(bus.overflow), 64'd1);
        n0 = n_acc;
        bus.sd_ack = 1'b1;
        wait_sb_empty("t3_drain", 40);
        step(4);
        check("t3_write_count", 64'(n_acc - n0), 64'd4);

        // 5: empty download; rise clears overflow, fall with empty FIFO pulses load_done
        bus.dl_active = 1'b1;
        step();
        check("t5_overflow_cleared", 64'(bus.overflow), 64'd0);
        ld0 = n_ld;
        bus.dl_active = 1'b0;
        step();
        @(negedge clk);
        check("t5_load_done_pulse", 64'(bus.load_done), 64'd1);
        @(negedge clk);
        check("t5_load_done_single", 64'(bus.load_done), 64'd0);
        step(3);
        check("t5_load_done_count", 64'(n_ld - ld0), 64'd1);

        // 4: streaming ten bytes with ack held high; fall coincides with the last byte
        bus.dl_active = 1'b1;
        step();
        n0 = n_acc;
        ld0 = n_ld;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            while (bus.dl_busy === 1'b1 && n < 20) begin
                step();
                n++;
            end
            check("t4_busy_release", 64'(bus.dl_busy), 64'd0);
            if (i == 9) bus.dl_active = 1'b0;
            if (i < 5) wr(25'(100 + i), 8'(8'h30 + i), 1'b1, 25'(100 + i), 2'b01);
            else       wr(P1 + 25'(200 + i), 8'(8'h30 + i), 1'b1, 25'(200 + i), 2'b10);
        end
        n = 0;
        while (n_ld == ld0 && n < 60) begin
            step();
            n++;
        end
        step(5);
        check("t4_load_done_count", 64'(n_ld - ld0), 64'd1);
        check("t4_load_done_timing", 64'(ld_cyc - last_acc_cyc), 64'd2);
        check("t4_write_count", 64'(n_acc - n0), 64'd10);
        check("t4_sb_empty", 64'(sb.size()), 64'd0);

        // 6: asynchronous reset in the middle of a request
        bus.sd_ack = 1'b0;
        wr(25'h1234, 8'hA5, 1'b1, 25'h1234, 2'b01);
        wr(P1 + 25'h0321, 8'h5A, 1'b1, 25'h0321, 2'b10);
        wr(25'h0777, 8'hC0, 1'b1, 25'h0777, 2'b01);
        check("t6_busy_before", 64'(bus.dl_busy), 64'd1);
        check("t6_sd_wr_before", 64'(bus.sd_wr), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_sd_wr_reset", 64'(bus.sd_wr), 64'd0);
        check("t6_addr_reset", 64'(bus.sd_wr_addr), 64'd0);
        check("t6_data_reset", 64'(bus.sd_data), 64'd0);
        check("t6_mask_reset", 64'(bus.sd_wr_mask), 64'd0);
        check("t6_busy_reset", 64'(bus.dl_busy), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        bus.sd_ack = 1'b1;
        n0 = n_acc;
        wr(25'd7, 8'hC3, 1'b1, 25'd7, 2'b01);
        wait_sb_empty("t6_drain", 20);
        step(3);
        check("t6_write_count", 64'(n_acc - n0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
